// File: rtl/tempsense_sar_ctrl.sv
// rtl/tempsense_sar_ctrl.sv - SAR conversion controller for a delay-line temperature sensor
//
// Runs an N_VDAC-bit successive-approximation search against the tempsense
// macro, averages 2^N_AVG_LOG2 conversions and hands the result to a
// valid/ready consumer.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   i_start           start one averaged measurement (sampled in IDLE only)
//   i_continuous      restart automatically from IDLE while high
//   i_tempdelay       asynchronous delay-line comparator output
//   i_ready           consumer accepts o_result
//   o_dac_data        DAC code to the macro
//   o_dac_en          DAC enable
//   o_precharge_n     active-low delay-line precharge
//   o_result          averaged SAR result
//   o_valid           o_result holds an unconsumed result
//   o_busy            high in every state except IDLE
//   o_overrun         sticky: an unconsumed result was overwritten
module tempsense_sar_ctrl #(
    parameter int N_VDAC     = 6,
    parameter int N_AVG_LOG2 = 2,
    parameter int T_MEAS     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic              i_tempdelay,
    input  logic              i_ready,
    output logic [N_VDAC-1:0] o_dac_data,
    output logic              o_dac_en,
    output logic              o_precharge_n,
    output logic [N_VDAC-1:0] o_result,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam int AW = N_VDAC + N_AVG_LOG2;
    localparam int IW = (N_VDAC > 1) ? $clog2(N_VDAC) : 1;
    localparam int CW = (N_AVG_LOG2 > 0) ? N_AVG_LOG2 : 1;
    localparam int MW = $clog2(T_MEAS);

    localparam logic [N_VDAC-1:0] ALL_ONES  = '1;
    localparam logic [N_VDAC-1:0] CODE_LSB  = {{(N_VDAC-1){1'b0}}, 1'b1};
    localparam logic [N_VDAC-1:0] CODE_MSB  = {1'b1, {(N_VDAC-1){1'b0}}};
    localparam logic [IW-1:0]     IDX_TOP   = IW'(N_VDAC - 1);
    localparam logic [CW-1:0]     CNT_LAST  = CW'((1 << N_AVG_LOG2) - 1);
    localparam logic [MW-1:0]     MEAS_LAST = MW'(T_MEAS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRECHARGE,
        MEASURE,
        EVAL,
        ACCUM
    } state_t;

    state_t            state;
    logic [1:0]        sync_q;
    logic              td_s;
    logic [N_VDAC-1:0] code;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt;
    logic [MW-1:0]     mcnt;
    logic [AW-1:0]     acc;

    logic [N_VDAC-1:0] bit_mask;
    logic [N_VDAC-1:0] eval_code;
    logic [AW-1:0]     acc_sum;

    assign td_s   = sync_q[1];
    assign o_busy = (state != IDLE);

    // A high delay-line output means the trial code overshot the sensor,
    // so the trial bit is dropped; the next-lower bit becomes the new trial.
    always_comb begin
        bit_mask  = CODE_LSB << idx;
        eval_code = td_s ? (code & ~bit_mask) : code;
        if (idx != '0) begin
            eval_code = eval_code | (bit_mask >> 1);
        end
        acc_sum = acc + AW'(code);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            sync_q        <= '0;
            code          <= '0;
            idx           <= '0;
            cnt           <= '0;
            mcnt          <= '0;
            acc           <= '0;
            o_result      <= '0;
            o_valid       <= 1'b0;
            o_overrun     <= 1'b0;
            o_dac_en      <= 1'b0;
            o_dac_data    <= ALL_ONES;
            o_precharge_n <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], i_tempdelay};

            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (i_start || i_continuous) begin
                        state         <= PRECHARGE;
                        code          <= CODE_MSB;
                        idx           <= IDX_TOP;
                        cnt           <= '0;
                        acc           <= '0;
                        o_dac_en      <= 1'b1;
                        o_dac_data    <= ALL_ONES;
                        o_precharge_n <= 1'b0;
                    end
                end
                PRECHARGE: begin
                    state         <= MEASURE;
                    mcnt          <= '0;
                    o_dac_data    <= code;
                    o_precharge_n <= 1'b1;
                end
                MEASURE: begin
                    if (mcnt == MEAS_LAST) begin
                        state <= EVAL;
                    end else begin
                        mcnt <= mcnt + 1'b1;
                    end
                end
                EVAL: begin
                    code          <= eval_code;
                    o_precharge_n <= 1'b0;
                    if (idx != '0) begin
                        idx        <= idx - 1'b1;
                        state      <= PRECHARGE;
                        o_dac_data <= ALL_ONES;
                    end else begin
                        state      <= ACCUM;
                        o_dac_data <= eval_code;
                    end
                end
                ACCUM: begin
                    if (cnt != CNT_LAST) begin
                        cnt        <= cnt + 1'b1;
                        acc        <= acc_sum;
                        code       <= CODE_MSB;
                        idx        <= IDX_TOP;
                        state      <= PRECHARGE;
                        o_dac_data <= ALL_ONES;
                    end else begin
                        o_result <= N_VDAC'(acc_sum >> N_AVG_LOG2);
                        o_valid  <= 1'b1;
                        // Overwriting a result the consumer never took.
                        if (o_valid && !i_ready) begin
                            o_overrun <= 1'b1;
                        end
                        acc        <= '0;
                        state      <= IDLE;
                        o_dac_en   <= 1'b0;
                        o_dac_data <= ALL_ONES;
                    end
                end
                default: begin
                    state         <= IDLE;
                    o_dac_en      <= 1'b0;
                    o_dac_data    <= ALL_ONES;
                    o_precharge_n <= 1'b0;
                end
            endcase
        end
    end

endmodule
